// File: rtl/dmem_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-port word memory.
// Sub-word stores are done as a read-modify-write because the memory has no byte enables.
module dmem_port_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [1:0]        req_we,
  input  logic [1:0]        req_size0,
  input  logic [1:0]        req_size1,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  input  logic [DATA_W-1:0] req_wdata0,
  input  logic [DATA_W-1:0] req_wdata1,
  output logic [1:0]        rsp_valid,
  output logic              rsp_err,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_read_data
);

  typedef enum logic [1:0] {StIdle, StRmwRd, StRmwWr} state_e;

  state_e state_q, state_d;
  logic   ptr_q, ptr_d;  // port that wins when both request

  logic              lat_port_q, lat_port_d;
  logic [ADDR_W-1:0] lat_addr_q, lat_addr_d;
  logic [1:0]        lat_size_q, lat_size_d;
  logic [DATA_W-1:0] lat_wdata_q, lat_wdata_d;
  logic [DATA_W-1:0] rmw_word_q, rmw_word_d;
  logic [1:0]        rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  logic              any_valid, grant, accept;
  logic [1:0]        grant_oh, lat_oh;
  logic              sel_we, sel_err;
  logic [1:0]        sel_size;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [DATA_W-1:0] load_shifted, load_data, rmw_mask, merged_word;

  always_comb begin
    any_valid = |req_valid;
    grant     = (&req_valid) ? ptr_q : req_valid[1];
    grant_oh  = {grant, ~grant};
    lat_oh    = {lat_port_q, ~lat_port_q};
    sel_we    = req_we[grant];
    sel_size  = grant ? req_size1  : req_size0;
    sel_addr  = grant ? req_addr1  : req_addr0;
    sel_wdata = grant ? req_wdata1 : req_wdata0;
    sel_err   = (sel_size == 2'b11) ||
                (sel_size == 2'b01 && sel_addr[0]) ||
                (sel_size == 2'b10 && sel_addr[1:0] != 2'b00);
    accept    = rst_n && (state_q == StIdle) && any_valid;

    load_shifted = mem_read_data >> {sel_addr[1:0], 3'b000};
    case (sel_size)
      2'b00:   load_data = load_shifted & 32'h0000_00ff;
      2'b01:   load_data = load_shifted & 32'h0000_ffff;
      default: load_data = load_shifted;
    endcase

    rmw_mask    = ((lat_size_q == 2'b00) ? 32'h0000_00ff : 32'h0000_ffff)
                  << {lat_addr_q[1:0], 3'b000};
    merged_word = (rmw_word_q & ~rmw_mask) |
                  ((lat_wdata_q << {lat_addr_q[1:0], 3'b000}) & rmw_mask);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ptr_q       <= 1'b0;
      lat_port_q  <= 1'b0;
      lat_addr_q  <= '0;
      lat_size_q  <= 2'b00;
      lat_wdata_q <= '0;
      rmw_word_q  <= '0;
      rsp_valid_q <= 2'b00;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      lat_port_q  <= lat_port_d;
      lat_addr_q  <= lat_addr_d;
      lat_size_q  <= lat_size_d;
      lat_wdata_q <= lat_wdata_d;
      rmw_word_q  <= rmw_word_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    lat_port_d  = lat_port_q;
    lat_addr_d  = lat_addr_q;
    lat_size_d  = lat_size_q;
    lat_wdata_d = lat_wdata_q;
    rmw_word_d  = rmw_word_q;
    rsp_valid_d = 2'b00;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    case (state_q)
      StIdle: begin
        if (accept) begin
          ptr_d = ~grant;
          if (sel_err) begin
            rsp_valid_d = grant_oh;
            rsp_err_d   = 1'b1;
          end else if (!sel_we) begin
            rsp_valid_d = grant_oh;
            rsp_rdata_d = load_data;
          end else if (sel_size == 2'b10) begin
            rsp_valid_d = grant_oh;
          end else begin
            lat_port_d  = grant;
            lat_addr_d  = sel_addr;
            lat_size_d  = sel_size;
            lat_wdata_d = sel_wdata;
            state_d     = StRmwRd;
          end
        end
      end
      StRmwRd: begin
        rmw_word_d = mem_read_data;
        state_d    = StRmwWr;
      end
      StRmwWr: begin
        rsp_valid_d = lat_oh;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Everything is gated by rst_n so a reset mid-RMW never reaches the memory.
  always_comb begin
    req_ready      = 2'b00;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_addr       = '0;
    mem_write_data = '0;
    if (rst_n) begin
      case (state_q)
        StIdle: begin
          if (any_valid) begin
            req_ready = grant_oh;
            if (!sel_err && !sel_we) begin
              mem_read = 1'b1;
              mem_addr = {sel_addr[ADDR_W-1:2], 2'b00};
            end else if (!sel_err && sel_size == 2'b10) begin
              mem_write      = 1'b1;
              mem_addr       = {sel_addr[ADDR_W-1:2], 2'b00};
              mem_write_data = sel_wdata;
            end
          end
        end
        StRmwRd: begin
          mem_read = 1'b1;
          mem_addr = {lat_addr_q[ADDR_W-1:2], 2'b00};
        end
        StRmwWr: begin
          mem_write      = 1'b1;
          mem_addr       = {lat_addr_q[ADDR_W-1:2], 2'b00};
          mem_write_data = merged_word;
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed scenarios plus a randomized run checked
// against a byte-level memory model and an arbitration/latency model.
module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req_valid, req_ready, req_we, req_size0, req_size1;
  logic [31:0] req_addr0, req_addr1, req_wdata0, req_wdata1;
  logic [1:0]  rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata, mem_addr, mem_write_data, mem_read_data;
  logic        mem_write, mem_read;

  int n_checks = 0;
  int n_pass   = 0;
  int rw_clash = 0;
  int rdy_clash = 0;

  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];

  dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size0(req_size0), .req_size1(req_size1),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_write(mem_write), .mem_read(mem_read), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_write) mem[mem_addr[11:2]] <= mem_write_data;
  assign mem_read_data = mem[mem_addr[11:2]];

  always @(negedge clk) begin
    if (mem_read && mem_write) rw_clash++;
    if (req_ready == 2'b11) rdy_clash++;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, want finish");
    $fatal(1, "timeout");
  end

  // ---------------- reference model ----------------
  function automatic bit is_err(input logic [1:0] size, input logic [31:0] addr);
    return (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) || (size == 2'd2 && addr % 4 != 0);
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [1:0] size);
    logic [31:0] v;
    v = ref_mem[addr[11:2]] >> (8 * (addr % 4));
    if (size == 2'd0) v = v % 256;
    else if (size == 2'd1) v = v % 65536;
    return v;
  endfunction

  task automatic ref_store(input logic [31:0] addr, input logic [1:0] size,
                           input logic [31:0] data);
    int nb;
    int b;
    logic [31:0] w;
    nb = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    b  = int'(addr % 4);
    w  = ref_mem[addr[11:2]];
    for (int i = 0; i < nb; i++) w[8*(b+i) +: 8] = data[8*i +: 8];
    ref_mem[addr[11:2]] = w;
  endtask

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int p, input bit we, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] wd);
    req_valid[p] = 1'b1;
    req_we[p]    = we;
    if (p == 0) begin
      req_size0 = size; req_addr0 = addr; req_wdata0 = wd;
    end else begin
      req_size1 = size; req_addr1 = addr; req_wdata1 = wd;
    end
  endtask

  task automatic release_port(input int p);
    req_valid[p] = 1'b0;
  endtask

  // Returns at posedge+1 of the cycle after the accept.
  task automatic issue(input int p, input bit we, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] wd, output bit acc);
    acc = 1'b0;
    drive(p, we, size, addr, wd);
    for (int i = 0; i < 8 && !acc; i++) begin
      @(negedge clk);
      if (req_ready[p]) acc = 1'b1;
      step();
    end
    release_port(p);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    drive(0, 1'b0, 2'd2, 32'h10, 32'h0);
    drive(1, 1'b1, 2'd2, 32'h14, 32'h1234);
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (req_ready !== 2'b00) $display("FAIL reset_ready: got %b, want 00", req_ready);
    else n_pass++;
    n_checks++;
    if ({rsp_valid, rsp_err, rsp_rdata} !== 35'h0)
      $display("FAIL reset_rsp: got %b/%b/%h, want 0", rsp_valid, rsp_err, rsp_rdata);
    else n_pass++;
    n_checks++;
    if ({mem_read, mem_write, mem_addr, mem_write_data} !== 66'h0)
      $display("FAIL reset_mem: got rd %b wr %b a %h d %h, want 0",
               mem_read, mem_write, mem_addr, mem_write_data);
    else n_pass++;
    step();
    req_valid = 2'b00;
    rst_n = 1'b1;
  endtask

  task automatic test_fill();
    bit acc;
    logic [31:0] d;
    for (int w = 0; w < 16; w++) begin
      d = $urandom;
      issue(0, 1'b1, 2'd2, 32'(w * 4), d, acc);
      ref_store(32'(w * 4), 2'd2, d);
      @(negedge clk);
      n_checks++;
      if (!acc || rsp_valid !== 2'b01 || rsp_err !== 1'b0)
        $display("FAIL fill_rsp: got acc %b valid %b err %b, want 1/01/0", acc, rsp_valid, rsp_err);
      else n_pass++;
      step();
    end
  endtask

  task automatic test_word_store_load();
    drive(0, 1'b1, 2'd2, 32'h10, 32'hdeadbeef);
    @(negedge clk);
    n_checks++;
    if (req_ready !== 2'b01 || mem_write !== 1'b1 || mem_addr !== 32'h10)
      $display("FAIL wsl_store: got rdy %b wr %b a %h, want 01/1/10", req_ready, mem_write, mem_addr);
    else n_pass++;
    ref_store(32'h10, 2'd2, 32'hdeadbeef);
    step();
    drive(0, 1'b0, 2'd2, 32'h10, 32'h0);
    @(negedge clk);
    n_checks++;
    if (req_ready !== 2'b01 || rsp_valid !== 2'b01 || mem_read !== 1'b1)
      $display("FAIL wsl_load_acc: got rdy %b rv %b rd %b, want 01/01/1", req_ready, rsp_valid, mem_read);
    else n_pass++;
    step();
    release_port(0);
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 2'b01 || rsp_rdata !== 32'hdeadbeef || rsp_rdata !== ref_load(32'h10, 2'd2))
      $display("FAIL wsl_load_rsp: got %b/%h, want 01/deadbeef", rsp_valid, rsp_rdata);
    else n_pass++;
    step();
  endtask

  task automatic test_rmw();
    bit acc;
    issue(0, 1'b1, 2'd2, 32'h20, 32'h11223344, acc);
    ref_store(32'h20, 2'd2, 32'h11223344);
    n_checks++;
    if (!acc) $display("FAIL rmw_preload: got no accept, want accept");
    else n_pass++;
    drive(1, 1'b1, 2'd0, 32'h21, 32'h000000aa);
    @(negedge clk);
    n_checks++;
    if (req_ready !== 2'b10) $display("FAIL rmw_accept: got %b, want 10", req_ready);
    else n_pass++;
    step();
    release_port(1);
    drive(0, 1'b0, 2'd2, 32'h20, 32'h0);
    @(negedge clk);
    n_checks++;
    if (req_ready !== 2'b00 || mem_read !== 1'b1 || mem_write !== 1'b0 || mem_addr !== 32'h20)
      $display("FAIL rmw_rd: got rdy %b rd %b wr %b a %h, want 00/1/0/20",
               req_ready, mem_read, mem_write, mem_addr);
    else n_pass++;
    step();
    @(negedge clk);
    n_checks++;
    if (req_ready !== 2'b00 || mem_write !== 1'b1 || mem_write_data !== 32'h1122aa44)
      $display("FAIL rmw_wr: got rdy %b wr %b d %h, want 00/1/1122aa44",
               req_ready, mem_write, mem_write_data);
    else n_pass++;
    ref_store(32'h21, 2'd0, 32'h000000aa);
    step();
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 2'b10 || rsp_err !== 1'b0 || req_ready !== 2'b01)
      $display("FAIL rmw_rsp: got rv %b err %b rdy %b, want 10/0/01", rsp_valid, rsp_err, req_ready);
    else n_pass++;
    step();
    drive(0, 1'b0, 2'd1, 32'h22, 32'h0);
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 2'b01 || rsp_rdata !== ref_load(32'h20, 2'd2))
      $display("FAIL rmw_word_back: got %b/%h, want 01/%h", rsp_valid, rsp_rdata, ref_load(32'h20, 2'd2));
    else n_pass++;
    step();
    release_port(0);
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 2'b01 || rsp_rdata !== 32'h00001122)
      $display("FAIL rmw_half_load: got %b/%h, want 01/00001122", rsp_valid, rsp_rdata);
    else n_pass++;
    step();
  endtask

  task automatic test_fairness();
    int prev;
    logic [1:0] want;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    drive(0, 1'b0, 2'd2, 32'h00, 32'h0);
    drive(1, 1'b0, 2'd2, 32'h04, 32'h0);
    prev = -1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      want = (i % 2 == 1) ? 2'b10 : 2'b01;
      n_checks++;
      if (req_ready !== want) $display("FAIL fair_grant%0d: got %b, want %b", i, req_ready, want);
      else n_pass++;
      if (prev >= 0) begin
        n_checks++;
        if (rsp_valid !== (prev == 1 ? 2'b10 : 2'b01) || rsp_rdata !== ref_load(32'(prev * 4), 2'd2))
          $display("FAIL fair_data%0d: got %b/%h, want port %0d data %h",
                   i, rsp_valid, rsp_rdata, prev, ref_load(32'(prev * 4), 2'd2));
        else n_pass++;
      end
      prev = i % 2;
      step();
    end
    req_valid = 2'b00;
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 2'b10 || rsp_rdata !== ref_load(32'h04, 2'd2))
      $display("FAIL fair_last: got %b/%h, want 10/%h", rsp_valid, rsp_rdata, ref_load(32'h04, 2'd2));
    else n_pass++;
    step();
  endtask

  task automatic test_misaligned();
    bit we;
    logic [1:0] sz;
    logic [31:0] a;
    bit acc;
    for (int t = 0; t < 4; t++) begin
      case (t)
        0: begin we = 1'b0; sz = 2'd2; a = 32'h13; end
        1: begin we = 1'b1; sz = 2'd1; a = 32'h21; end
        2: begin we = 1'b0; sz = 2'd3; a = 32'h00; end
        default: begin we = 1'b1; sz = 2'd2; a = 32'h22; end
      endcase
      drive(0, we, sz, a, 32'hcafef00d);
      @(negedge clk);
      n_checks++;
      if (req_ready !== 2'b01 || mem_read !== 1'b0 || mem_write !== 1'b0)
        $display("FAIL misal_acc%0d: got rdy %b rd %b wr %b, want 01/0/0", t, req_ready, mem_read, mem_write);
      else n_pass++;
      step();
      release_port(0);
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 2'b01 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0)
        $display("FAIL misal_rsp%0d: got %b/%b/%h, want 01/1/0", t, rsp_valid, rsp_err, rsp_rdata);
      else n_pass++;
      step();
    end
    issue(0, 1'b0, 2'd2, 32'h20, 32'h0, acc);
    @(negedge clk);
    n_checks++;
    if (!acc || rsp_rdata !== ref_load(32'h20, 2'd2) || rsp_err !== 1'b0)
      $display("FAIL misal_unchanged: got %h, want %h", rsp_rdata, ref_load(32'h20, 2'd2));
    else n_pass++;
    step();
  endtask

  task automatic test_reset_rmw();
    drive(0, 1'b1, 2'd1, 32'h30, 32'h00005a5a);
    @(negedge clk);
    n_checks++;
    if (req_ready !== 2'b01) $display("FAIL rstrmw_acc: got %b, want 01", req_ready);
    else n_pass++;
    step();
    release_port(0);
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++;
      if ({req_ready, rsp_valid, rsp_err, mem_read, mem_write, mem_addr, mem_write_data} !== 71'h0)
        $display("FAIL rstrmw_out%0d: got rdy %b rv %b rd %b wr %b a %h, want all 0",
                 i, req_ready, rsp_valid, mem_read, mem_write, mem_addr);
      else n_pass++;
      step();
    end
    rst_n = 1'b1;
    drive(0, 1'b0, 2'd2, 32'h30, 32'h0);
    @(negedge clk);
    n_checks++;
    if (req_ready !== 2'b01 || rsp_valid !== 2'b00)
      $display("FAIL rstrmw_idle: got rdy %b rv %b, want 01/00", req_ready, rsp_valid);
    else n_pass++;
    step();
    release_port(0);
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 2'b01 || rsp_rdata !== ref_load(32'h30, 2'd2))
      $display("FAIL rstrmw_load: got %b/%h, want 01/%h", rsp_valid, rsp_rdata, ref_load(32'h30, 2'd2));
    else n_pass++;
    step();
  endtask

  task automatic test_random();
    bit          pend [2];
    bit          pw   [2];
    logic [1:0]  ps   [2];
    logic [31:0] pa   [2];
    logic [31:0] pd   [2];
    bit          ev   [4];
    int          ep   [4];
    bit          ee   [4];
    bit          ec   [4];
    logic [31:0] ed   [4];
    int last, busy, g, slot, lat, r;
    logic [1:0]  want_rdy;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    last = 1;
    busy = 0;
    for (int i = 0; i < 2; i++) pend[i] = 1'b0;
    for (int i = 0; i < 4; i++) ev[i] = 1'b0;
    for (int k = 0; k < 300; k++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && k < 290 && $urandom_range(0, 9) < 6) begin
          r     = int'($urandom_range(0, 9));
          ps[p] = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
          pa[p] = $urandom_range(0, 63);
          if ($urandom_range(0, 9) < 7) begin
            if (ps[p] == 2'd1) pa[p] = pa[p] & ~32'h1;
            if (ps[p] == 2'd2) pa[p] = pa[p] & ~32'h3;
          end
          pw[p] = 1'($urandom_range(0, 1));
          pd[p] = $urandom;
          pend[p] = 1'b1;
          drive(p, pw[p], ps[p], pa[p], pd[p]);
        end
      end
      @(negedge clk);
      slot = k % 4;
      n_checks++;
      if (ev[slot]) begin
        if (rsp_valid !== (ep[slot] == 1 ? 2'b10 : 2'b01) || rsp_err !== ee[slot] ||
            (ec[slot] && rsp_rdata !== ed[slot]))
          $display("FAIL rand_rsp@%0d: got %b/%b/%h, want port %0d err %b data %h",
                   k, rsp_valid, rsp_err, rsp_rdata, ep[slot], ee[slot], ed[slot]);
        else n_pass++;
      end else begin
        if (rsp_valid !== 2'b00) $display("FAIL rand_idle@%0d: got %b, want 00", k, rsp_valid);
        else n_pass++;
      end
      ev[slot] = 1'b0;
      g = -1;
      if (busy > 0) busy--;
      else if (pend[0] && pend[1]) g = (last == 0) ? 1 : 0;
      else if (pend[0]) g = 0;
      else if (pend[1]) g = 1;
      want_rdy = (g < 0) ? 2'b00 : (g == 1) ? 2'b10 : 2'b01;
      n_checks++;
      if (req_ready !== want_rdy) $display("FAIL rand_ready@%0d: got %b, want %b", k, req_ready, want_rdy);
      else n_pass++;
      if (g >= 0) begin
        lat = 1;
        ee[0] = 1'b0;
        slot = 0;
        if (is_err(ps[g], pa[g])) begin
          slot = (k + 1) % 4; ee[slot] = 1'b1; ec[slot] = 1'b1; ed[slot] = 32'h0;
        end else if (!pw[g]) begin
          slot = (k + 1) % 4; ee[slot] = 1'b0; ec[slot] = 1'b1; ed[slot] = ref_load(pa[g], ps[g]);
        end else begin
          ref_store(pa[g], ps[g], pd[g]);
          if (ps[g] != 2'd2) begin
            busy = 2;
            lat  = 3;
          end
          slot = (k + lat) % 4; ee[slot] = 1'b0; ec[slot] = 1'b0; ed[slot] = 32'h0;
        end
        ev[slot] = 1'b1;
        ep[slot] = g;
        last = g;
        pend[g] = 1'b0;
      end
      step();
      if (g >= 0) release_port(g);
    end
    req_valid = 2'b00;
  endtask

  task automatic test_invariants();
    n_checks++;
    if (rw_clash != 0) $display("FAIL rd_wr_overlap: got %0d cycles, want 0", rw_clash);
    else n_pass++;
    n_checks++;
    if (rdy_clash != 0) $display("FAIL both_ready: got %0d cycles, want 0", rdy_clash);
    else n_pass++;
  endtask

  initial begin
    req_valid  = 2'b00;
    req_we     = 2'b00;
    req_size0  = 2'd0;
    req_size1  = 2'd0;
    req_addr0  = '0;
    req_addr1  = '0;
    req_wdata0 = '0;
    req_wdata1 = '0;
    test_reset();
    test_fill();
    test_word_store_load();
    test_rmw();
    test_fairness();
    test_misaligned();
    test_reset_rmw();
    test_random();
    test_invariants();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Shares the single-port, word-addressed data memory between two requesters: port 0 (core load/store unit) and port 1 (loader/DMA). Arbitration is round-robin with a valid/ready request handshake and a one-cycle registered response pulse. The block also handles byte and halfword stores by doing a read-modify-write, because the memory has no byte enables. It sits between the requesters and the data memory, which has a combinational read, a synchronous write and uses `addr[11:2]` as its word index.

## Interface
- `ADDR_W`, 32: request/memory address width.
- `DATA_W`, 32: data width. Fixed at 32; sub-word logic assumes 4 bytes per word.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `req_valid[1:0]` input 2: per-port request valid.
- `req_ready[1:0]` output 2: per-port accept; the transfer occurs on the cycle where `valid && ready`.
- `req_we[1:0]` input 2: 1 = store, 0 = load.
- `req_size0`, `req_size1` input 2 each: 00 byte, 01 half, 10 word, 11 illegal.
- `req_addr0`, `req_addr1` input ADDR_W each: byte address.
- `req_wdata0`, `req_wdata1` input 32 each: store data, right-aligned.
- `rsp_valid[1:0]` output 2: one-cycle completion pulse per port.
- `rsp_err` output 1: qualifies `rsp_valid`; set for misaligned or illegal size.
- `rsp_rdata` output 32: load data, shifted to bit 0 and zero-extended.
- `mem_addr` output ADDR_W: memory address, driven with bits [1:0] = 0.
- `mem_write_data` output 32: memory write data.
- `mem_write` output 1: memory write strobe.
- `mem_read` output 1: memory read enable.
- `mem_read_data` input 32: combinational memory read data.

## Operation
- States: IDLE, RMW_RD, RMW_WR.
- `req_ready[i]` is high only in IDLE and only for the granted port. It is combinational from `req_valid` and the priority pointer.
- Arbitration:
  - Only one port valid: that port is granted.
  - Both ports valid: the port not granted last wins.
  - The priority pointer updates only on an accept.
  - After reset the pointer favours port 0.
- Alignment check at accept:
  - Half with `addr[0]=1`, word with `addr[1:0]!=0`, or size 11 is an error.
  - On error: no memory access; response has `rsp_err=1` and `rsp_rdata=0`.
- Load (any legal size), in IDLE on accept:
  - Drive `mem_read=1` and `mem_addr={addr[31:2],2'b00}`.
  - Register `mem_read_data >> (8*addr[1:0])`, masked to the access size.
- Word store, in IDLE on accept: drive `mem_write=1` with `mem_write_data=wdata`.
- Byte/half store:
  - On accept: latch port, address, size and data, then go to RMW_RD.
  - RMW_RD: `mem_read=1`; capture the word.
  - RMW_WR: `mem_write=1`; write the captured word with the addressed byte or half replaced. Then return to IDLE.
- Memory outputs are 0 whenever not in use.
- `mem_read` and `mem_write` are never high in the same cycle.

## Timing
- Reset values:
  - `req_ready=0` during reset; `rsp_valid=0`, `rsp_err=0`, `rsp_rdata=0`.
  - `mem_read=0`, `mem_write=0`, `mem_addr=0`, `mem_write_data=0`.
  - State IDLE, pointer favours port 0.
- Load, word store and error response: `rsp_valid[i]` pulses in cycle A+1, where A is the accept cycle.
- Sub-word store timeline:
  - A: accept.
  - A+1: RMW_RD.
  - A+2: RMW_WR, memory written at the end of A+2.
  - A+3: `rsp_valid` pulse.
  - `req_ready` is 0 in cycles A+1 and A+2.
- Throughput: one word access per cycle. Back-to-back accepts are allowed while in IDLE.
- Write visibility: a store accepted in cycle A is visible to a load accepted in A+1 or later.
- Responses have no backpressure. Requesters must sample the pulse.
- Reset asserted in RMW_RD or RMW_WR:
  - The pending write is dropped and the memory is not written.
  - No response is issued.
  - The block is in IDLE on the first cycle after `rst_n` rises.

## Test plan
- Word store then word load:
  - Stimulus: port 0 stores 0xDEADBEEF at 0x10 (accept in cycle 1), then loads 0x10 (accept in cycle 2).
  - Response: `rsp_valid[0]` in cycles 2 and 3; `rsp_rdata`=0xDEADBEEF in cycle 3.
- Sub-word read-modify-write:
  - Stimulus: preload word 0x11223344 at 0x20; port 1 stores byte 0xAA at 0x21.
  - Response: `req_ready=00` for two cycles; memory word becomes 0x1122AA44; `rsp_valid[1]` at A+3. A following half load at 0x22 returns 0x00001122.
- Fairness:
  - Stimulus: both ports hold valid word loads for 6 cycles.
  - Response: grants alternate 0,1,0,1,0,1 starting with port 0 after reset. Both `req_ready` bits are never 1 in the same cycle.
- Misaligned access:
  - Stimulus: port 0 issues a word load at 0x13, then a half store at 0x21.
  - Response: `rsp_err=1`, `rsp_rdata=0`, `mem_read=mem_write=0` for both; memory is unchanged.
- Reset in RMW_RD:
  - Stimulus: assert `rst_n=0` while in RMW_RD.
  - Response: target word unchanged, no `rsp_valid`, all outputs 0. After release, a new word load succeeds with 1-cycle latency.
